// File: rtl/pc_sequencer_if.sv
// Fetch-side handshake bundle for pc_sequencer: branch/jump resolution in, fetch PC and status out.
interface pc_sequencer_if;
  logic        advance;
  logic        redirect_req;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        in_delay_slot;
  logic        active;
  logic        addr_error;
  logic        slot_violation;
  logic [15:0] taken_count;

  modport master (
    output advance, redirect_req, redirect_target,
    input  pc, pc_plus4, in_delay_slot, active, addr_error, slot_violation, taken_count
  );

  modport slave (
    input  advance, redirect_req, redirect_target,
    output pc, pc_plus4, in_delay_slot, active, addr_error, slot_violation, taken_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// MIPS program-counter sequencer with one-instruction branch delay slot and halt-on-jump-to-zero.
// Optional feature macro: PC_SEQ_TAKEN_COUNT_EN builds the saturating taken-redirect counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input logic          clk,
  input logic          rst_n,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {RUN, DELAY, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic        addr_err_q, addr_err_d;
  logic        slot_viol_q, slot_viol_d;
  logic        accept_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_VECTOR;
      pending_q   <= '0;
      addr_err_q  <= 1'b0;
      slot_viol_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pending_q   <= pending_d;
      addr_err_q  <= addr_err_d;
      slot_viol_q <= slot_viol_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pending_d       = pending_q;
    addr_err_d      = addr_err_q;
    slot_viol_d     = slot_viol_q;
    accept_redirect = 1'b0;
    if (bus.advance) begin
      unique case (state_q)
        RUN: begin
          pc_d = pc_q + 32'd4;
          if (bus.redirect_req) begin
            pending_d       = bus.redirect_target;
            state_d         = DELAY;
            accept_redirect = 1'b1;
          end
        end
        DELAY: begin
          // A redirect from the slot itself is flagged but never steers control flow.
          if (bus.redirect_req) slot_viol_d = 1'b1;
          if (pending_q[1:0] != 2'b00) begin
            addr_err_d = 1'b1;
            state_d    = HALT;
          end else if (pending_q == '0) begin
            pc_d    = '0;
            state_d = HALT;
          end else begin
            pc_d    = pending_q;
            state_d = RUN;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PC_SEQ_TAKEN_COUNT_EN
  logic [15:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  always_comb begin
    count_d = count_q;
    if (accept_redirect && count_q != '1) count_d = count_q + 16'd1;
  end

  assign bus.taken_count = count_q;
`else
  logic unused_accept;
  assign unused_accept   = accept_redirect;
  assign bus.taken_count = '0;
`endif

  assign bus.pc             = pc_q;
  assign bus.pc_plus4       = pc_q + 32'd4;
  assign bus.in_delay_slot  = (state_q == DELAY);
  assign bus.active         = (state_q != HALT);
  assign bus.addr_error     = addr_err_q;
  assign bus.slot_violation = slot_viol_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: sequential fetch, delay slot, halt and error paths.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

`ifdef PC_SEQ_TAKEN_COUNT_EN
  localparam logic [15:0] TC_ONE = 16'd1;
  localparam logic [15:0] TC_TWO = 16'd2;
`else
  localparam logic [15:0] TC_ONE = 16'd0;
  localparam logic [15:0] TC_TWO = 16'd0;
`endif

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_VECTOR(32'hBFC0_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic adv, input logic req, input logic [31:0] tgt);
    bus.advance         = adv;
    bus.redirect_req    = req;
    bus.redirect_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.advance         = 1'b0;
    bus.redirect_req    = 1'b0;
    bus.redirect_target = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_pc(input string name, input logic [31:0] exp_pc, input logic exp_ds, input logic exp_act);
    checks++;
    if (bus.pc !== exp_pc || bus.in_delay_slot !== exp_ds || bus.active !== exp_act) begin
      errors++;
      $display("FAIL %s: pc=%h ds=%b act=%b, expected pc=%h ds=%b act=%b",
               name, bus.pc, bus.in_delay_slot, bus.active, exp_pc, exp_ds, exp_act);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_pc("reset", 32'hBFC0_0000, 1'b0, 1'b1);
    checks++;
    if (bus.addr_error !== 1'b0 || bus.slot_violation !== 1'b0 || bus.taken_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_flags: ae=%b sv=%b tc=%h, expected 0 0 0000",
               bus.addr_error, bus.slot_violation, bus.taken_count);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp [3];
    exp[0] = 32'hBFC0_0004; exp[1] = 32'hBFC0_0008; exp[2] = 32'hBFC0_000C;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0);
      check_pc($sformatf("seq%0d", i), exp[i], 1'b0, 1'b1);
    end
    checks++;
    if (bus.pc_plus4 !== 32'hBFC0_0010) begin
      errors++;
      $display("FAIL pc_plus4: got %h expected %h", bus.pc_plus4, 32'hBFC0_0010);
    end
  endtask

  task automatic test_redirect_stall_wrap();
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'hBFC0_0100);
    check_pc("slot_first", 32'hBFC0_0008, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0);
    check_pc("slot_stall", 32'hBFC0_0008, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0);
    check_pc("target", 32'hBFC0_0100, 1'b0, 1'b1);
    checks++;
    if (bus.taken_count !== TC_ONE) begin
      errors++;
      $display("FAIL taken_count1: got %h expected %h", bus.taken_count, TC_ONE);
    end
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    check_pc("wrap_slot", 32'hBFC0_0104, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0);
    check_pc("wrap_top", 32'hFFFF_FFFC, 1'b0, 1'b1);
    checks++;
    if (bus.pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL pc_plus4_wrap: got %h expected 00000000", bus.pc_plus4);
    end
    step(1'b1, 1'b0, 32'h0);
    check_pc("wrap_zero", 32'h0000_0000, 1'b0, 1'b1);
    checks++;
    if (bus.taken_count !== TC_TWO) begin
      errors++;
      $display("FAIL taken_count2: got %h expected %h", bus.taken_count, TC_TWO);
    end
  endtask

  task automatic test_halt_zero();
    do_reset();
    step(1'b1, 1'b1, 32'h0);
    check_pc("halt_slot", 32'hBFC0_0004, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0);
    check_pc("halt", 32'h0000_0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0040);
    step(1'b1, 1'b0, 32'h0);
    check_pc("halt_hold", 32'h0000_0000, 1'b0, 1'b0);
    checks++;
    if (bus.taken_count !== TC_ONE || bus.addr_error !== 1'b0) begin
      errors++;
      $display("FAIL halt_frozen: tc=%h ae=%b expected tc=%h ae=0", bus.taken_count, bus.addr_error, TC_ONE);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'hBFC0_0102);
    check_pc("mis_slot", 32'hBFC0_0008, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0);
    check_pc("mis_halt", 32'hBFC0_0008, 1'b0, 1'b0);
    checks++;
    if (bus.addr_error !== 1'b1) begin
      errors++;
      $display("FAIL addr_error: got %b expected 1", bus.addr_error);
    end
  endtask

  task automatic test_slot_violation();
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'hBFC0_0200);
    step(1'b1, 1'b1, 32'hBFC0_0300);
    check_pc("sv_target", 32'hBFC0_0200, 1'b0, 1'b1);
    checks++;
    if (bus.slot_violation !== 1'b1 || bus.taken_count !== TC_ONE) begin
      errors++;
      $display("FAIL slot_violation: sv=%b tc=%h expected sv=1 tc=%h", bus.slot_violation, bus.taken_count, TC_ONE);
    end
    step(1'b1, 1'b0, 32'h0);
    check_pc("sv_next", 32'hBFC0_0204, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 1'b1, 32'hBFC0_0400);
    check_pc("ar_slot", 32'hBFC0_0004, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_pc("ar_async", 32'hBFC0_0000, 1'b0, 1'b1);
    #2;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 32'h0);
    check_pc("ar_resume", 32'hBFC0_0004, 1'b0, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    bus.advance         = 1'b0;
    bus.redirect_req    = 1'b0;
    bus.redirect_target = '0;
    test_reset();
    test_sequential();
    test_redirect_stall_wrap();
    test_halt_zero();
    test_misaligned();
    test_slot_violation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
